lcd_write_sequencer: RTL and testbench
======================================

// Module: lcd_write_sequencer
// PURPOSE
//   Transfer sequencer for the 4-bit character LCD (50 MHz Clock). It accepts one
//   byte plus register-select via valid/ready and splits it into upper then lower
//   nibble. For each nibble it drives oLCD_Data and generates the enable pulse with
//   setup, hold and settle timing. It enforces the post-byte execution wait.
//   Sits between the LCD init/text FSM and the LCD pins. It is the only driver of the pins.
// PARAMETERS
//   SETUP_CYC       2      cycles data/RS stable before E rises (>=40 ns)
//   ENABLE_CYC      12     cycles E held high (>=230 ns)
//   HOLD_CYC        1      cycles data/RS held after E falls (>=10 ns)
//   NIBBLE_GAP_CYC  50     cycles between upper and lower nibble (1 us)
//   BYTE_GAP_CYC    2000   cycles after lower nibble, normal command/data (40 us)
//   LONG_GAP_CYC    82000  cycles after lower nibble when iLongWait=1 (1.64 ms)
//   CNT_W           17     delay counter width; must hold max(*_CYC)-1
// PORTS
//   Clock                    in   1  system clock, 50 MHz, rising edge
//   Reset                    in   1  synchronous, active-high
//   iData                    in   8  byte to write, sampled only on accept
//   iRS                      in   1  register select for this byte (0 cmd, 1 data)
//   iLongWait                in   1  use LONG_GAP_CYC after this byte (clear/home)
//   iValid                   in   1  request; accepted when iValid && oReady at edge
//   oReady                   out  1  high only in IDLE
//   oDone                    out  1  one-cycle pulse when a byte's full sequence ends
//   oLCD_Enabled             out  1  LCD E
//   oLCD_RegisterSelect      out  1  LCD RS
//   oLCD_StrataFlashControl  out  1  constant 1 (keeps StrataFlash off the bus)
//   oLCD_ReadWrite           out  1  constant 0 (write only)
//   oLCD_Data                out  4  LCD DB[7:4]
// BEHAVIOUR
//   - Reset (sync): state IDLE, counter 0, E=0, RS=0, Data=0, oDone=0, oReady=1.
//     SF=1 and RW=0 at all times. Reset mid-transfer aborts it: E low and oReady=1
//     on the next cycle. No oDone for the aborted byte.
//   - All outputs are registered. oReady is a decode of state==IDLE.
//   - States: IDLE -> HI_SETUP -> HI_EN -> HI_HOLD -> NIB_GAP -> LO_SETUP -> LO_EN
//     -> LO_HOLD -> BYTE_GAP -> IDLE.
//   - Each timed state lasts exactly its *_CYC cycles. On entry the counter loads
//     N-1, it decrements every cycle, and the state advances when the counter is 0.
//   - Accept: an edge with iValid=1 in IDLE latches iData, iRS and iLongWait, then
//     enters HI_SETUP. iValid outside IDLE is ignored, not queued.
//   - oLCD_Data = latched[7:4] in HI_*, latched[3:0] in LO_*, and 0 elsewhere.
//     RS = latched RS in *_SETUP/*_EN/*_HOLD, and 0 elsewhere.
//   - E=1 only in HI_EN and LO_EN. Data/RS never change while E=1 or in the cycle
//     E falls.
//   - BYTE_GAP length is LONG_GAP_CYC if the latched iLongWait=1, else BYTE_GAP_CYC.
//   - Latency with defaults: accept edge to oReady=1 is 2+12+1+50+2+12+1+2000 =
//     2080 cycles, or 82080 with long wait.
//   - oDone=1 in the first IDLE cycle after BYTE_GAP. It coincides with oReady
//     rising, and a new request may be accepted in that same cycle.
//   - Back-to-back requests therefore need no idle cycles between sequences.
// TESTING
//   1 Reset 5 cycles -> E=0, RS=0, Data=0, RW=0, SF=1, oReady=1, oDone=0.
//   2 Write 0x41 with RS=1 -> Data=4 for 15 cycles, with E high in cycles 3..14
//     after accept. 50 gap cycles with E=0. Data=1 for 15 cycles, with E high for 12.
//     oDone pulse and oReady=1 at cycle 2080.
//   3 Write 0x01, RS=0, iLongWait=1 -> RS=0 throughout; oReady returns at cycle 82080.
//   4 iValid held high with 0x48 then 0x49 -> 0x48 accepted; 0x49 held off while busy.
//     0x49 accepted in the oDone cycle. Exactly two E pulses per byte.
//   5 iValid pulsed mid-transfer (NIB_GAP) -> no effect; sequence timing unchanged.
//   6 Reset during LO_EN -> E=0 and oReady=1 next cycle; no oDone. Next write is
//     normal.
//   Checker: E-high run length always ENABLE_CYC; Data/RS stable from SETUP start
//   to HOLD end.

Source files
------------

// File: rtl/lcd_write_sequencer.sv
// rtl/lcd_write_sequencer.sv - 4-bit character LCD write sequencer (byte -> two timed nibble strobes)
// Sole driver of the LCD pins; one byte per valid/ready handshake, registered outputs.
module lcd_write_sequencer #(
    parameter int SETUP_CYC      = 2,
    parameter int ENABLE_CYC     = 12,
    parameter int HOLD_CYC       = 1,
    parameter int NIBBLE_GAP_CYC = 50,
    parameter int BYTE_GAP_CYC   = 2000,
    parameter int LONG_GAP_CYC   = 82000,
    parameter int CNT_W          = 17
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] iData,
    input  logic       iRS,
    input  logic       iLongWait,
    input  logic       iValid,
    output logic       oReady,
    output logic       oDone,
    output logic       oLCD_Enabled,
    output logic       oLCD_RegisterSelect,
    output logic       oLCD_StrataFlashControl,
    output logic       oLCD_ReadWrite,
    output logic [3:0] oLCD_Data
);

    typedef enum logic [3:0] {
        IDLE,
        HI_SETUP,
        HI_EN,
        HI_HOLD,
        NIB_GAP,
        LO_SETUP,
        LO_EN,
        LO_HOLD,
        BYTE_GAP
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LOAD  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] ENABLE_LOAD = CNT_W'(ENABLE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] NGAP_LOAD   = CNT_W'(NIBBLE_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] BGAP_LOAD   = CNT_W'(BYTE_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] LGAP_LOAD   = CNT_W'(LONG_GAP_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] delayCnt;
    logic [3:0]       loNibble;
    logic             latchedRS;
    logic             latchedLong;
    logic             cntZero;

    assign cntZero                 = (delayCnt == '0);
    assign oLCD_StrataFlashControl = 1'b1;
    assign oLCD_ReadWrite          = 1'b0;

    // Outputs are set on the transition into each state so they are registered
    // and already valid during the first cycle of that state.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state               <= IDLE;
            delayCnt            <= '0;
            loNibble            <= 4'd0;
            latchedRS           <= 1'b0;
            latchedLong         <= 1'b0;
            oReady              <= 1'b1;
            oDone               <= 1'b0;
            oLCD_Enabled        <= 1'b0;
            oLCD_RegisterSelect <= 1'b0;
            oLCD_Data           <= 4'd0;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (iValid) begin
                        loNibble            <= iData[3:0];
                        latchedRS           <= iRS;
                        latchedLong         <= iLongWait;
                        oLCD_Data           <= iData[7:4];
                        oLCD_RegisterSelect <= iRS;
                        oReady              <= 1'b0;
                        delayCnt            <= SETUP_LOAD;
                        state               <= HI_SETUP;
                    end
                end
                HI_SETUP: begin
                    if (cntZero) begin
                        oLCD_Enabled <= 1'b1;
                        delayCnt     <= ENABLE_LOAD;
                        state        <= HI_EN;
                    end else begin
                        delayCnt <= delayCnt - 1'b1;
                    end
                end
                HI_EN: begin
                    if (cntZero) begin
                        oLCD_Enabled <= 1'b0;
                        delayCnt     <= HOLD_LOAD;
                        state        <= HI_HOLD;
                    end else begin
                        delayCnt <= delayCnt - 1'b1;
                    end
                end
                HI_HOLD: begin
                    if (cntZero) begin
                        oLCD_Data           <= 4'd0;
                        oLCD_RegisterSelect <= 1'b0;
                        delayCnt            <= NGAP_LOAD;
                        state               <= NIB_GAP;
                    end else begin
                        delayCnt <= delayCnt - 1'b1;
                    end
                end
                NIB_GAP: begin
                    if (cntZero) begin
                        oLCD_Data           <= loNibble;
                        oLCD_RegisterSelect <= latchedRS;
                        delayCnt            <= SETUP_LOAD;
                        state               <= LO_SETUP;
                    end else begin
                        delayCnt <= delayCnt - 1'b1;
                    end
                end
                LO_SETUP: begin
                    if (cntZero) begin
                        oLCD_Enabled <= 1'b1;
                        delayCnt     <= ENABLE_LOAD;
                        state        <= LO_EN;
                    end else begin
                        delayCnt <= delayCnt - 1'b1;
                    end
                end
                LO_EN: begin
                    if (cntZero) begin
                        oLCD_Enabled <= 1'b0;
                        delayCnt     <= HOLD_LOAD;
                        state        <= LO_HOLD;
                    end else begin
                        delayCnt <= delayCnt - 1'b1;
                    end
                end
                LO_HOLD: begin
                    if (cntZero) begin
                        oLCD_Data           <= 4'd0;
                        oLCD_RegisterSelect <= 1'b0;
                        delayCnt            <= latchedLong ? LGAP_LOAD : BGAP_LOAD;
                        state               <= BYTE_GAP;
                    end else begin
                        delayCnt <= delayCnt - 1'b1;
                    end
                end
                BYTE_GAP: begin
                    if (cntZero) begin
                        oReady <= 1'b1;
                        oDone  <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        delayCnt <= delayCnt - 1'b1;
                    end
                end
                default: begin
                    oReady              <= 1'b1;
                    oLCD_Enabled        <= 1'b0;
                    oLCD_RegisterSelect <= 1'b0;
                    oLCD_Data           <= 4'd0;
                    delayCnt            <= '0;
                    state               <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// tb/tb_lcd_write_sequencer.sv - self-checking bench for lcd_write_sequencer
// Per-cycle trace compared against a phase-boundary model of the write sequence.
module tb_lcd_write_sequencer;

    localparam int SETUP_CYC      = 2;
    localparam int ENABLE_CYC     = 12;
    localparam int HOLD_CYC       = 1;
    localparam int NIBBLE_GAP_CYC = 50;
    localparam int BYTE_GAP_CYC   = 2000;
    localparam int LONG_GAP_CYC   = 82000;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [7:0] iData;
    logic       iRS;
    logic       iLongWait;
    logic       iValid;
    logic       oReady;
    logic       oDone;
    logic       oLCD_Enabled;
    logic       oLCD_RegisterSelect;
    logic       oLCD_StrataFlashControl;
    logic       oLCD_ReadWrite;
    logic [3:0] oLCD_Data;

    int checkCount = 0;
    int failCount  = 0;

    lcd_write_sequencer dut (
        .Clock                   (Clock),
        .Reset                   (Reset),
        .iData                   (iData),
        .iRS                     (iRS),
        .iLongWait               (iLongWait),
        .iValid                  (iValid),
        .oReady                  (oReady),
        .oDone                   (oDone),
        .oLCD_Enabled            (oLCD_Enabled),
        .oLCD_RegisterSelect     (oLCD_RegisterSelect),
        .oLCD_StrataFlashControl (oLCD_StrataFlashControl),
        .oLCD_ReadWrite          (oLCD_ReadWrite),
        .oLCD_Data               (oLCD_Data)
    );

    always #10 Clock = ~Clock;

    // Pin snapshot: {E, RS, Data[3:0], Ready, Done, SF, RW}
    function automatic logic [9:0] pins();
        return {oLCD_Enabled, oLCD_RegisterSelect, oLCD_Data, oReady, oDone,
                oLCD_StrataFlashControl, oLCD_ReadWrite};
    endfunction

    // Expected pins k edges after the accept edge (k=0 is the accept edge itself)
    function automatic logic [9:0] model(input int k, input logic [7:0] d,
                                         input logic rs, input logic lw);
        int t1, t2, t3, t4, t5, t6, t7, tEnd;
        t1   = SETUP_CYC;
        t2   = t1 + ENABLE_CYC;
        t3   = t2 + HOLD_CYC;
        t4   = t3 + NIBBLE_GAP_CYC;
        t5   = t4 + SETUP_CYC;
        t6   = t5 + ENABLE_CYC;
        t7   = t6 + HOLD_CYC;
        tEnd = t7 + (lw ? LONG_GAP_CYC : BYTE_GAP_CYC);
        if (k < t3)        return {(k >= t1 && k < t2), rs, d[7:4], 4'b0010};
        else if (k < t4)   return {1'b0, 1'b0, 4'h0, 4'b0010};
        else if (k < t7)   return {(k >= t5 && k < t6), rs, d[3:0], 4'b0010};
        else if (k < tEnd) return {1'b0, 1'b0, 4'h0, 4'b0010};
        else               return {1'b0, 1'b0, 4'h0, 4'b1110};
    endfunction

    function automatic int seqLen(input logic lw);
        return 2 * (SETUP_CYC + ENABLE_CYC + HOLD_CYC) + NIBBLE_GAP_CYC
               + (lw ? LONG_GAP_CYC : BYTE_GAP_CYC);
    endfunction

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Issues one byte from an idle sampling point and follows it to the oDone cycle.
    // pulseAt: cycle index at which a stray one-cycle iValid is driven (-1 none).
    // holdNext: keep iValid high with nextData during the whole sequence.
    task automatic run_sequence(input string name, input logic [7:0] d, input logic rs,
                                input logic lw, input int pulseAt, input logic holdNext,
                                input logic [7:0] nextData, input logic nextRS);
        int tEnd;
        logic [9:0] exp;
        tEnd      = seqLen(lw);
        iData     = d;
        iRS       = rs;
        iLongWait = lw;
        iValid    = 1'b1;
        step();
        for (int k = 0; k <= tEnd; k++) begin
            exp = model(k, d, rs, lw);
            checkCount++;
            if (pins() !== exp) begin
                failCount++;
                $display("FAIL %s k=%0d pins got=%b expected=%b", name, k, pins(), exp);
            end
            if (holdNext) begin
                iValid    = 1'b1;
                iData     = nextData;
                iRS       = nextRS;
                iLongWait = 1'b0;
            end else begin
                iValid    = (k == pulseAt);
                iData     = 8'($urandom);
                iRS       = 1'($urandom);
                iLongWait = 1'($urandom);
            end
            if (k < tEnd) step();
        end
    endtask

    // E-high run length and data/RS stability while E is high and on its falling cycle
    int         runLen = 0;
    logic       prevE  = 1'b0;
    logic [3:0] heldData;
    logic       heldRS;
    always @(negedge Clock) begin
        if (Reset) begin
            runLen = 0;
            prevE  = 1'b0;
        end else begin
            if (oLCD_Enabled) begin
                if (!prevE) begin
                    heldData = oLCD_Data;
                    heldRS   = oLCD_RegisterSelect;
                    runLen   = 1;
                end else begin
                    runLen++;
                    checkCount++;
                    if ({oLCD_RegisterSelect, oLCD_Data} !== {heldRS, heldData}) begin
                        failCount++;
                        $display("FAIL e_stable rs/data got=%b/%h expected=%b/%h",
                                 oLCD_RegisterSelect, oLCD_Data, heldRS, heldData);
                    end
                end
            end else if (prevE) begin
                checkCount++;
                if (runLen != ENABLE_CYC) begin
                    failCount++;
                    $display("FAIL e_run_length got=%0d expected=%0d", runLen, ENABLE_CYC);
                end
                checkCount++;
                if ({oLCD_RegisterSelect, oLCD_Data} !== {heldRS, heldData}) begin
                    failCount++;
                    $display("FAIL e_fall_hold rs/data got=%b/%h expected=%b/%h",
                             oLCD_RegisterSelect, oLCD_Data, heldRS, heldData);
                end
            end
            prevE = oLCD_Enabled;
        end
    end

    task automatic test_reset();
        Reset     = 1'b1;
        iValid    = 1'b0;
        iData     = 8'h00;
        iRS       = 1'b0;
        iLongWait = 1'b0;
        repeat (5) step();
        checkCount++;
        if (pins() !== 10'b00_0000_1010) begin
            failCount++;
            $display("FAIL reset_state pins got=%b expected=%b", pins(), 10'b00_0000_1010);
        end
        Reset = 1'b0;
        step();
        checkCount++;
        if (pins() !== 10'b00_0000_1010) begin
            failCount++;
            $display("FAIL idle_after_reset pins got=%b expected=%b", pins(), 10'b00_0000_1010);
        end
    endtask

    task automatic test_write_data();
        run_sequence("write_41", 8'h41, 1'b1, 1'b0, -1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_long_wait();
        run_sequence("long_01", 8'h01, 1'b0, 1'b1, -1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_sequence("b2b_48", 8'h48, 1'b1, 1'b0, -1, 1'b1, 8'h49, 1'b1);
        run_sequence("b2b_49", 8'h49, 1'b1, 1'b0, -1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset_abort();
        logic [7:0] d;
        int         loEn;
        d      = 8'($urandom);
        loEn   = 2 * SETUP_CYC + ENABLE_CYC + HOLD_CYC + NIBBLE_GAP_CYC + 3;
        iData  = d;
        iRS    = 1'b1;
        iValid = 1'b1;
        step();
        iValid = 1'b0;
        for (int k = 1; k <= loEn; k++) step();
        checkCount++;
        if (pins() !== model(loEn, d, 1'b1, 1'b0)) begin
            failCount++;
            $display("FAIL abort_in_lo_en pins got=%b expected=%b", pins(),
                     model(loEn, d, 1'b1, 1'b0));
        end
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        checkCount++;
        if (pins() !== 10'b00_0000_1010) begin
            failCount++;
            $display("FAIL abort_next_cycle pins got=%b expected=%b", pins(), 10'b00_0000_1010);
        end
        for (int k = 0; k < 20; k++) begin
            step();
            checkCount++;
            if (pins() !== 10'b00_0000_1010) begin
                failCount++;
                $display("FAIL abort_no_done k=%0d pins got=%b expected=%b", k, pins(),
                         10'b00_0000_1010);
            end
        end
        // Follow-up byte also carries a stray request in the middle of the nibble gap
        run_sequence("post_abort", 8'($urandom), 1'($urandom), 1'b0,
                     SETUP_CYC + ENABLE_CYC + HOLD_CYC + 10, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        test_reset();
        test_write_data();
        test_long_wait();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
